// File: rtl/aibcr3_rxdig_pkg.sv
// Shared definitions for the multi-lane AIB RX deserialiser.
// Contents: irxen mode encodings, the control state enum, the PRBS7 tap mask
// and a helper that tells whether a mode carries data.
package aibcr3_rxdig_pkg;

    localparam logic [2:0] MODE_ASYNC = 3'b000;
    localparam logic [2:0] MODE_DDR   = 3'b001;
    localparam logic [2:0] MODE_DIS   = 3'b010;
    localparam logic [2:0] MODE_CLK   = 3'b011;
    localparam logic [2:0] MODE_SDR   = 3'b100;

    typedef enum logic [1:0] {
        StDis,
        StFlush,
        StRun
    } state_e;

    // x^7 + x^6 + 1; history bit 0 is the newest bit, so taps are the bits 7 and 6 back.
    localparam logic [6:0] PRBS7_POLY = 7'b110_0000;

    function automatic logic is_data_mode(input logic [2:0] mode);
        return (mode == MODE_DDR) || (mode == MODE_SDR);
    endfunction

endpackage

// File: rtl/aibcr3_rxdig_deser_lane.sv
// Single-lane accumulator of the RX deserialiser.
// Ports:
//   iclkin_dist, irstb : clock, asynchronous active-low reset
//   idat0, idat1       : earlier / later bit of this lane's pair
//   clear              : drop the partial word (not accumulating this cycle)
//   slip               : discard idat0 this cycle (the later bit goes first)
//   emit               : a word completes this cycle
//   cnt                : shared fill level, position of the next bit
//   add                : number of bits appended this cycle (0..2)
//   word               : last completed word, LSB oldest; held between strobes
module aibcr3_rxdig_deser_lane #(
    parameter int unsigned RATIO = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             iclkin_dist,
    input  logic             irstb,
    input  logic             idat0,
    input  logic             idat1,
    input  logic             clear,
    input  logic             slip,
    input  logic             emit,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       add,
    output logic [RATIO-1:0] word
);

    logic [RATIO:0] acc_q;
    logic [RATIO:0] ins;
    logic           first;

    always_comb begin
        first = slip ? idat1 : idat0;
        ins   = acc_q;
        for (int unsigned i = 0; i <= RATIO; i++) begin
            if ((add != 2'd0) && (cnt == CNT_W'(i))) begin
                ins[i] = first;
            end
            if ((add == 2'd2) && ((cnt + CNT_W'(1)) == CNT_W'(i))) begin
                ins[i] = idat1;
            end
        end
    end

    always_ff @(posedge iclkin_dist or negedge irstb) begin
        if (!irstb) begin
            acc_q <= '0;
            word  <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (emit) begin
            word  <= ins[RATIO-1:0];
            acc_q <= ins >> RATIO;
        end else begin
            acc_q <= ins;
        end
    end

endmodule

// File: rtl/aibcr3_rxdig_deser.sv
// Multi-lane AIB RX deserialiser with lane-wide bit-slip and mode-change flush.
// Ports:
//   iclkin_dist, irstb : sole clock, asynchronous active-low reset
//   irxen              : shared mode (001 DDR, 100 SDR, 010 disable, 011 clock, else idle)
//   idat0, idat1       : per-lane earlier / later captured bit
//   i_slip             : one-cycle bit-slip request
//   odat_word          : lane k at [k*RATIO +: RATIO], LSB oldest
//   odat_vld           : one-cycle strobe qualifying odat_word
//   rx_disable         : registered mode is 010
//   clkbuf_en          : registered mode is 011
//   sync_datbuf_en     : control state is RUN
//   o_slip_busy        : a slip is pending
// Optional: define AIBCR3_RXDIG_DESER_PRBS_EN to add a PRBS7 checker on lane 0
// with outputs o_prbs_lock and o_prbs_err_cnt (saturating).
module aibcr3_rxdig_deser
    import aibcr3_rxdig_pkg::*;
#(
    parameter int unsigned NLANE     = 4,
    parameter int unsigned RATIO     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                   iclkin_dist,
    input  logic                   irstb,
    input  logic [2:0]             irxen,
    input  logic [NLANE-1:0]       idat0,
    input  logic [NLANE-1:0]       idat1,
    input  logic                   i_slip,
    output logic [NLANE*RATIO-1:0] odat_word,
    output logic                   odat_vld,
    output logic                   rx_disable,
    output logic                   clkbuf_en,
    output logic                   sync_datbuf_en,
    output logic                   o_slip_busy
`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
    ,
    output logic                   o_prbs_lock,
    output logic [7:0]             o_prbs_err_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(RATIO + 2);

    state_e           state_q;
    logic [2:0]       mode_q;
    logic [2:0]       flush_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] sum;
    logic [1:0]       add_cnt;
    logic             change;
    logic             run_go;
    logic             slip_take;
    logic             emit;

    // A mode change is seen the cycle irxen differs from the registered mode; it
    // wins over any word completing in that cycle.
    always_comb begin
        change    = (irxen != mode_q);
        run_go    = (state_q == StRun) && !change;
        slip_take = run_go && o_slip_busy;
        add_cnt   = 2'd0;
        if (run_go) begin
            if (mode_q == MODE_DDR) begin
                add_cnt = o_slip_busy ? 2'd1 : 2'd2;
            end else begin
                add_cnt = o_slip_busy ? 2'd0 : 2'd1;
            end
        end
        sum   = cnt_q + CNT_W'(add_cnt);
        emit  = run_go && (sum >= CNT_W'(RATIO));
        cnt_d = '0;
        if (run_go) begin
            cnt_d = emit ? (sum - CNT_W'(RATIO)) : sum;
        end
    end

    always_ff @(posedge iclkin_dist or negedge irstb) begin
        if (!irstb) begin
            state_q     <= StDis;
            mode_q      <= MODE_ASYNC;
            flush_cnt_q <= '0;
            cnt_q       <= '0;
            odat_vld    <= 1'b0;
            rx_disable  <= 1'b0;
            clkbuf_en   <= 1'b0;
            o_slip_busy <= 1'b0;
        end else begin
            mode_q     <= irxen;
            rx_disable <= (irxen == MODE_DIS);
            clkbuf_en  <= (irxen == MODE_CLK);
            cnt_q      <= cnt_d;
            odat_vld   <= emit;
            if (change) begin
                state_q     <= StFlush;
                flush_cnt_q <= '0;
                o_slip_busy <= 1'b0;
            end else begin
                unique case (state_q)
                    StFlush: begin
                        o_slip_busy <= 1'b0;
                        if (flush_cnt_q == 3'(FLUSH_CYC - 1)) begin
                            state_q     <= is_data_mode(mode_q) ? StRun : StDis;
                            flush_cnt_q <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + 3'd1;
                        end
                    end
                    StRun: begin
                        // The pending slip is consumed this cycle; a request now is ignored.
                        if (o_slip_busy) begin
                            o_slip_busy <= 1'b0;
                        end else if (i_slip) begin
                            o_slip_busy <= 1'b1;
                        end
                    end
                    default: begin
                        o_slip_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sync_datbuf_en = (state_q == StRun);

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        aibcr3_rxdig_deser_lane #(
            .RATIO (RATIO),
            .CNT_W (CNT_W)
        ) u_lane (
            .iclkin_dist (iclkin_dist),
            .irstb       (irstb),
            .idat0       (idat0[k]),
            .idat1       (idat1[k]),
            .clear       (!run_go),
            .slip        (slip_take),
            .emit        (emit),
            .cnt         (cnt_q),
            .add         (add_cnt),
            .word        (odat_word[k*RATIO +: RATIO])
        );
    end

`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
    logic [6:0] prbs_hist_q, prbs_hist_d;
    logic [2:0] prbs_seed_q, prbs_seed_d;
    logic [4:0] prbs_good_q, prbs_good_d;
    logic       prbs_lock_d;
    logic [7:0] prbs_err_d;

    // Bits are checked oldest first. Until locked the history follows the received
    // stream (self-sync); once locked it free-runs so a single bit error counts once.
    always_comb begin
        logic b;
        logic p;
        b           = 1'b0;
        p           = 1'b0;
        prbs_hist_d = prbs_hist_q;
        prbs_seed_d = prbs_seed_q;
        prbs_good_d = prbs_good_q;
        prbs_lock_d = o_prbs_lock;
        prbs_err_d  = o_prbs_err_cnt;
        if (odat_vld) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                b = odat_word[i];
                p = ^(prbs_hist_d & PRBS7_POLY);
                if (prbs_seed_d < 3'd7) begin
                    prbs_hist_d = {prbs_hist_d[5:0], b};
                    prbs_seed_d = prbs_seed_d + 3'd1;
                end else if (prbs_lock_d) begin
                    if ((b != p) && (prbs_err_d != 8'hFF)) begin
                        prbs_err_d = prbs_err_d + 8'd1;
                    end
                    prbs_hist_d = {prbs_hist_d[5:0], p};
                end else begin
                    prbs_hist_d = {prbs_hist_d[5:0], b};
                    if (b != p) begin
                        prbs_good_d = '0;
                    end else begin
                        prbs_good_d = prbs_good_d + 5'd1;
                        if (prbs_good_d == 5'd16) begin
                            prbs_lock_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge iclkin_dist or negedge irstb) begin
        if (!irstb) begin
            prbs_hist_q    <= '0;
            prbs_seed_q    <= '0;
            prbs_good_q    <= '0;
            o_prbs_lock    <= 1'b0;
            o_prbs_err_cnt <= '0;
        end else if (state_q != StRun) begin
            prbs_hist_q    <= '0;
            prbs_seed_q    <= '0;
            prbs_good_q    <= '0;
            o_prbs_lock    <= 1'b0;
            o_prbs_err_cnt <= '0;
        end else begin
            prbs_hist_q    <= prbs_hist_d;
            prbs_seed_q    <= prbs_seed_d;
            prbs_good_q    <= prbs_good_d;
            o_prbs_lock    <= prbs_lock_d;
            o_prbs_err_cnt <= prbs_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_aibcr3_rxdig_deser.sv
module tb_aibcr3_rxdig_deser;

    logic        clk = 1'b0;
    logic        irstb;
    logic [2:0]  irxen;
    logic [3:0]  idat0;
    logic [3:0]  idat1;
    logic        i_slip;
    logic [15:0] word;
    logic        vld, rxdis, clkbuf, sync, busy;
    logic [11:0] word3;
    logic        vld3, rxdis3, clkbuf3, sync3, busy3;
`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
    logic        prbs_lock, prbs_lock3;
    logic [7:0]  prbs_err, prbs_err3;
    logic [6:0]  lfsr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    aibcr3_rxdig_deser #(.NLANE(4), .RATIO(4), .FLUSH_CYC(2)) dut (
        .iclkin_dist    (clk),
        .irstb          (irstb),
        .irxen          (irxen),
        .idat0          (idat0),
        .idat1          (idat1),
        .i_slip         (i_slip),
        .odat_word      (word),
        .odat_vld       (vld),
        .rx_disable     (rxdis),
        .clkbuf_en      (clkbuf),
        .sync_datbuf_en (sync),
        .o_slip_busy    (busy)
`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
        ,
        .o_prbs_lock    (prbs_lock),
        .o_prbs_err_cnt (prbs_err)
`endif
    );

    aibcr3_rxdig_deser #(.NLANE(4), .RATIO(3), .FLUSH_CYC(2)) dut3 (
        .iclkin_dist    (clk),
        .irstb          (irstb),
        .irxen          (irxen),
        .idat0          (idat0),
        .idat1          (idat1),
        .i_slip         (i_slip),
        .odat_word      (word3),
        .odat_vld       (vld3),
        .rx_disable     (rxdis3),
        .clkbuf_en      (clkbuf3),
        .sync_datbuf_en (sync3),
        .o_slip_busy    (busy3)
`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
        ,
        .o_prbs_lock    (prbs_lock3),
        .o_prbs_err_cnt (prbs_err3)
`endif
    );

    typedef struct {
        logic [2:0]  irxen;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic        slip;
        logic        vld;
        logic [15:0] word;
        logic        sync;
        logic        rxdis;
        logic        clkbuf;
        logic        busy;
    } row_t;

    row_t rows[$];

    function automatic row_t mk(input logic [2:0] m, input logic [3:0] d0, input logic [3:0] d1,
                                input logic s, input logic v, input logic [15:0] w,
                                input logic sy, input logic rd, input logic cb, input logic bz);
        row_t r;
        r.irxen = m;  r.d0 = d0;     r.d1 = d1;     r.slip = s;
        r.vld = v;    r.word = w;    r.sync = sy;   r.rxdis = rd;
        r.clkbuf = cb; r.busy = bz;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
    task automatic prbs_bit(output logic b);
        b    = lfsr[6];
        lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    endtask
`endif

    initial begin
        logic b0;
        logic b1;
        b0 = 1'b0;
        b1 = 1'b0;
        irstb  = 1'b0;
        irxen  = 3'b000;
        idat0  = 4'h0;
        idat1  = 4'h0;
        i_slip = 1'b0;

        // DDR: 1,0 / 1,1 -> 1101; slip; 001->010 mid-word; 011; 100 SDR restart.
        rows.push_back(mk(3'b001, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'h0, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'hF, 1'b0, 1'b1, 16'hDDDD, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b0, 16'hDDDD, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'hF, 1'b0, 1'b1, 16'hDDDD, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b0, 16'hDDDD, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b1));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b001, 4'hF, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b010, 4'hF, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(3'b010, 4'hF, 4'h0, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(3'b010, 4'hF, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0));
        rows.push_back(mk(3'b011, 4'h0, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h1, 4'hF, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'h0, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'hF, 1'b0, 1'b0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h1, 4'h0, 1'b0, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0));
        rows.push_back(mk(3'b100, 4'h0, 4'hF, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, 1'b0, 1'b0));

        // Reset state.
        step();
        step();
        check("rst vld", 32'(vld), 32'd0);
        check("rst word", 32'(word), 32'd0);
        check("rst sync", 32'(sync), 32'd0);
        check("rst rxdis", 32'(rxdis), 32'd0);
        check("rst clkbuf", 32'(clkbuf), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        irstb = 1'b1;

        foreach (rows[i]) begin
            irxen  = rows[i].irxen;
            idat0  = rows[i].d0;
            idat1  = rows[i].d1;
            i_slip = rows[i].slip;
            step();
            check($sformatf("r%0d vld", i), 32'(vld), 32'(rows[i].vld));
            check($sformatf("r%0d word", i), 32'(word), 32'(rows[i].word));
            check($sformatf("r%0d sync", i), 32'(sync), 32'(rows[i].sync));
            check($sformatf("r%0d rxdis", i), 32'(rxdis), 32'(rows[i].rxdis));
            check($sformatf("r%0d clkbuf", i), 32'(clkbuf), 32'(rows[i].clkbuf));
            check($sformatf("r%0d busy", i), 32'(busy), 32'(rows[i].busy));
        end

        // Asynchronous reset mid-word, between clock edges.
        irstb = 1'b0;
        #2;
        check("arst word", 32'(word), 32'd0);
        check("arst sync", 32'(sync), 32'd0);
        check("arst vld", 32'(vld), 32'd0);
        #1;
        irstb = 1'b1;

        // RATIO=3 DDR: bits 1,1,0,1,0,0 -> 3'b011 then 3'b001.
        irxen = 3'b001;
        idat0 = 4'h0;
        idat1 = 4'h0;
        repeat (3) step();
        check("r3 sync", 32'(sync3), 32'd1);
        idat0 = 4'hF; idat1 = 4'hF;
        step();
        check("r3 p0 vld", 32'(vld3), 32'd0);
        idat0 = 4'h0; idat1 = 4'hF;
        step();
        check("r3 p1 vld", 32'(vld3), 32'd1);
        check("r3 p1 word", 32'(word3), 32'h6DB);
        idat0 = 4'h0; idat1 = 4'h0;
        step();
        check("r3 p2 vld", 32'(vld3), 32'd1);
        check("r3 p2 word", 32'(word3), 32'h249);

`ifdef AIBCR3_RXDIG_DESER_PRBS_EN
        irstb = 1'b0;
        #2;
        irstb = 1'b1;
        irxen = 3'b001;
        idat0 = 4'h0;
        idat1 = 4'h0;
        repeat (3) step();
        lfsr = 7'h7F;
        for (int c = 0; c < 20; c++) begin
            prbs_bit(b0);
            prbs_bit(b1);
            idat0 = {4{b0}};
            idat1 = {4{b1}};
            step();
        end
        check("prbs lock", 32'(prbs_lock), 32'd1);
        check("prbs err0", 32'(prbs_err), 32'd0);
        for (int c = 0; c < 10; c++) begin
            prbs_bit(b0);
            prbs_bit(b1);
            idat0 = {4{b0}};
            idat1 = {4{b1}};
            if (c == 0) idat0[0] = ~b0;
            step();
        end
        check("prbs err1", 32'(prbs_err), 32'd1);
        check("prbs lock2", 32'(prbs_lock), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
